// File: rtl/bpu_pkg.sv
// Shared constants for the fetch-stage branch predictor.
// Update kinds, counter seeds and the PC bus width.
package bpu_pkg;

  localparam int PC_BUS = 32;

  typedef enum logic [1:0] {
    BPU_KIND_NONE = 2'd0,
    BPU_KIND_BR   = 2'd1,
    BPU_KIND_JUMP = 2'd2
  } bpu_kind_e;

  localparam logic [1:0] BPU_CTR_INIT  = 2'b01;
  localparam logic [1:0] BPU_CTR_ALLOC = 2'b10;
  localparam logic [1:0] BPU_CTR_JUMP  = 2'b11;

endpackage

// File: rtl/bpu_ctr.sv
// 2-bit saturating counter next-value function.
// Pure combinational; used on the table update path.
module bpu_ctr (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/bpu.sv
// Direct-mapped branch predictor with 2-bit counters.
// Combinational lookup, one-cycle update, stall-aware.
module bpu
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES),
  parameter int TAGW    = 30 - IDXW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stop,
  input  logic [PC_BUS-1:0] pc_f,
  output logic              pred_taken,
  output logic [PC_BUS-1:0] npc_pred,
  input  logic              upd_valid,
  input  logic [1:0]        upd_kind,
  input  logic [PC_BUS-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [PC_BUS-1:0] upd_target,
  input  logic              upd_mispred,
  output logic [31:0]       cnt_branch,
  output logic [31:0]       cnt_mispred
);

  logic              valid_q  [ENTRIES];
  logic [TAGW-1:0]   tag_q    [ENTRIES];
  logic [PC_BUS-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;

  assign idx = pc_f[IDXW+1:2];
  assign tag = pc_f[31:IDXW+2];
  assign hit = valid_q[idx] & (tag_q[idx] == tag);

  assign pred_taken = hit & ctr_q[idx][1];
  assign npc_pred   = pred_taken ? target_q[idx]
                                 : pc_f + 32'd4;

  logic [IDXW-1:0] uidx;
  logic [TAGW-1:0] utag;
  logic            uhit;
  logic            is_br;
  logic            is_jump;
  logic            accept;
  logic [1:0]      ctr_nxt;

  assign uidx    = upd_pc[IDXW+1:2];
  assign utag    = upd_pc[31:IDXW+2];
  assign uhit    = valid_q[uidx] & (tag_q[uidx] == utag);
  assign is_br   = upd_kind == BPU_KIND_BR;
  assign is_jump = upd_kind == BPU_KIND_JUMP;
  assign accept  = upd_valid & ~stop & (is_br | is_jump);

  bpu_ctr u_ctr (
    .ctr   (ctr_q[uidx]),
    .taken (upd_taken),
    .nxt   (ctr_nxt)
  );

  // Word-offset bits never select an entry.
  logic unused_lsb;
  assign unused_lsb = ^{pc_f[1:0], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BPU_CTR_INIT;
      end
    end else if (accept) begin
      unique case (1'b1)
        is_jump: begin
          valid_q[uidx]  <= 1'b1;
          tag_q[uidx]    <= utag;
          target_q[uidx] <= upd_target;
          ctr_q[uidx]    <= BPU_CTR_JUMP;
        end
        is_br: begin
          if (uhit) begin
            ctr_q[uidx] <= ctr_nxt;
            if (upd_taken) target_q[uidx] <= upd_target;
          end else if (upd_taken) begin
            valid_q[uidx]  <= 1'b1;
            tag_q[uidx]    <= utag;
            target_q[uidx] <= upd_target;
            ctr_q[uidx]    <= BPU_CTR_ALLOC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else if (accept) begin
      cnt_branch <= cnt_branch + 32'd1;
      if (upd_mispred) cnt_mispred <= cnt_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpu.sv
// Directed bench for bpu with an array-based reference model.
// Literal expectations pin the model at key points.
module tb_bpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stop;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] npc_pred;
  logic        upd_valid;
  logic [1:0]  upd_kind;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_mispred;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  bpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stop        (stop),
    .pc_f        (pc_f),
    .pred_taken  (pred_taken),
    .npc_pred    (npc_pred),
    .upd_valid   (upd_valid),
    .upd_kind    (upd_kind),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .cnt_branch  (cnt_branch),
    .cnt_mispred (cnt_mispred)
  );

  // Reference model: 16 entries, index = word address mod 16.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic int ui(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned ut(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[ui(pc)] && m_tag[ui(pc)] == ut(pc);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_hit(pc) && m_ctr[ui(pc)] >= 2;
  endfunction

  function automatic logic [31:0] m_npc(logic [31:0] pc);
    logic [31:0] r;
    r = m_pred(pc) ? m_target[ui(pc)] : pc + 32'd4;
    return r;
  endfunction

  function automatic int sat(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i]  <= 0;
        m_tag[i]    <= 0;
        m_target[i] <= 0;
        m_ctr[i]    <= 1;
      end
      m_br <= 0;
      m_mp <= 0;
    end else if (upd_valid && !stop
                 && (upd_kind == 2'd1 || upd_kind == 2'd2)) begin
      m_br <= m_br + 1;
      if (upd_mispred) m_mp <= m_mp + 1;
      if (upd_kind == 2'd2) begin
        m_valid[ui(upd_pc)]  <= 1;
        m_tag[ui(upd_pc)]    <= ut(upd_pc);
        m_target[ui(upd_pc)] <= upd_target;
        m_ctr[ui(upd_pc)]    <= 3;
      end else if (m_hit(upd_pc)) begin
        m_ctr[ui(upd_pc)] <= sat(m_ctr[ui(upd_pc)], upd_taken);
        if (upd_taken) m_target[ui(upd_pc)] <= upd_target;
      end else if (upd_taken) begin
        m_valid[ui(upd_pc)]  <= 1;
        m_tag[ui(upd_pc)]    <= ut(upd_pc);
        m_target[ui(upd_pc)] <= upd_target;
        m_ctr[ui(upd_pc)]    <= 2;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(pc_f)});
      chk("model npc_pred", npc_pred, m_npc(pc_f));
      chk("model cnt_branch", cnt_branch, m_br);
      chk("model cnt_mispred", cnt_mispred, m_mp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(logic [1:0] k, logic [31:0] pc, logic t,
                     logic [31:0] tg, logic mp);
    upd_valid   = 1;
    upd_kind    = k;
    upd_pc      = pc;
    upd_taken   = t;
    upd_target  = tg;
    upd_mispred = mp;
  endtask

  task automatic idle();
    upd_valid   = 0;
    upd_kind    = 0;
    upd_pc      = 0;
    upd_taken   = 0;
    upd_target  = 0;
    upd_mispred = 0;
  endtask

  task automatic look(string nm, logic [31:0] pc, logic t,
                      logic [31:0] npc);
    pc_f = pc;
    #1;
    chk({nm, " taken"}, {31'd0, pred_taken}, {31'd0, t});
    chk({nm, " npc"}, npc_pred, npc);
  endtask

  initial begin
    rst_n = 0;
    stop  = 0;
    pc_f  = 32'h100;
    idle();
    tick();
    chk_en = 1;
    look("reset", 32'h100, 0, 32'h104);
    chk("reset cnt_branch", cnt_branch, 0);
    chk("reset cnt_mispred", cnt_mispred, 0);
    rst_n = 1;

    upd(2'd1, 32'h100, 1, 32'h80, 1);
    tick();
    idle();
    look("alloc", 32'h100, 1, 32'h80);
    chk("alloc cnt_branch", cnt_branch, 1);
    chk("alloc cnt_mispred", cnt_mispred, 1);

    upd(2'd1, 32'h100, 0, 32'h104, 0);
    tick();
    look("ctr1", 32'h100, 0, 32'h104);
    tick();
    tick();
    upd(2'd1, 32'h100, 1, 32'h80, 0);
    tick();
    idle();
    look("sat0", 32'h100, 0, 32'h104);
    upd(2'd1, 32'h100, 1, 32'h80, 0);
    tick();
    idle();
    look("ctr2", 32'h100, 1, 32'h80);
    chk("cnt after ctr walk", cnt_branch, 6);

    upd(2'd2, 32'h40, 1, 32'h200, 0);
    tick();
    idle();
    look("alias", 32'h140, 0, 32'h144);
    look("jump", 32'h40, 1, 32'h200);
    look("evicted", 32'h100, 0, 32'h104);

    stop = 1;
    upd(2'd1, 32'h40, 0, 32'h44, 1);
    tick();
    tick();
    tick();
    chk("stall cnt_branch", cnt_branch, 7);
    look("stall live", 32'h40, 1, 32'h200);
    stop = 0;
    tick();
    idle();
    chk("unstall cnt_branch", cnt_branch, 8);
    chk("unstall cnt_mispred", cnt_mispred, 2);
    look("one write", 32'h40, 1, 32'h200);

    pc_f = 32'h108;
    upd(2'd1, 32'h108, 1, 32'h500, 0);
    #1;
    chk("no bypass", npc_pred, 32'h10C);
    tick();
    idle();
    look("after write", 32'h108, 1, 32'h500);

    look("wrap", 32'hFFFF_FFFC, 0, 32'h0);

    upd(2'd3, 32'h10C, 1, 32'h900, 1);
    tick();
    idle();
    look("kind3", 32'h10C, 0, 32'h110);
    chk("kind3 cnt", cnt_branch, 9);

    rst_n = 0;
    upd(2'd2, 32'h108, 1, 32'h600, 1);
    tick();
    idle();
    rst_n = 1;
    look("rst wins", 32'h108, 0, 32'h10C);
    chk("rst cnt_branch", cnt_branch, 0);
    chk("rst cnt_mispred", cnt_mispred, 0);

    upd(2'd2, 32'h20, 1, 32'h700, 0);
    tick();
    idle();
    look("lsb ignored", 32'h23, 1, 32'h700);
    tick();
    tick();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
